// File: rtl/mem_access_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// slave: the access unit's view; master: core and memory side.
interface mem_access_if #(
    parameter int ADDR_BITS = 24
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [ADDR_BITS-1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_fault;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_wren;
    logic [31:0]          mem_q;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access stage: sub-word loads, rotated word loads,
// sub-word stores by read-modify-write on a word-only memory port.
// Ports: clock, reset_n (sync, active low), bus (mem_access_if.slave).
module mem_access_unit #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 signed_q, signed_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] merge_q, merge_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 fault_q, fault_d;
    logic [ADDR_BITS-1:0] maddr_q, maddr_d;
    logic [DATA_BITS-1:0] mwdata_q, mwdata_d;
    logic                 wren;

    // Lane select via a doubled-word right shift; the same shift
    // gives the ARMv4 rotation for word loads.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] q,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  lane
    );
        logic [63:0] dbl;
        logic [31:0] rot;
        logic [15:0] h;
        logic [31:0] r;
        dbl = {q, q} >> {lane, 3'b000};
        rot = dbl[31:0];
        h   = lane[1] ? q[31:16] : q[15:0];
        unique case (1'b1)
            size[1]:            r = rot;
            !size[1] && size[0]: r = {{16{sgn & h[15]}}, h};
            default:            r = {{24{sgn & rot[7]}}, rot[7:0]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic        half,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = old;
        if (half) begin
            if (lane[1]) r[31:16] = wd[15:0];
            else         r[15:0]  = wd[15:0];
        end else begin
            r[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        wren     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    fault_d  = (bus.req_size == 2'b01) && bus.req_addr[0];
                    if (fault_d) begin
                        state_d = RESP;
                    end else begin
                        maddr_d = {bus.req_addr[ADDR_BITS-1:2], 2'b00};
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    rdata_d = fmt_load(bus.mem_q, size_q, signed_q,
                                       addr_q[1:0]);
                    state_d = RESP;
                end else if (size_q[1]) begin
                    wren     = 1'b1;
                    mwdata_d = wdata_q;
                    state_d  = RESP;
                end else begin
                    merge_d = bus.mem_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wren     = 1'b1;
                mwdata_d = merge_store(merge_q, wdata_q, size_q[0],
                                       addr_q[1:0]);
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Write data is combinational during the write cycle and
    // holds the last driven value otherwise.
    assign bus.mem_wdata  = mwdata_d;
    assign bus.mem_wren   = wren & reset_n;
    assign bus.mem_addr   = maddr_q;
    assign bus.req_ready  = reset_n && (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word memory
// model and a scoreboard of expected responses.
module tb_mem_access_unit;
    logic clock;
    logic reset_n;
    int   passes;
    int   total;

    mem_access_if #(.ADDR_BITS(24)) bus ();

    mem_access_unit #(.ADDR_BITS(24), .DATA_BITS(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [64];
    assign bus.mem_q = mem[bus.mem_addr[7:2]];
    always @(posedge clock) begin
        if (bus.mem_wren) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        g;
        logic [23:0] a;
        logic [31:0] d;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          wcnt;
        int          rcnt;
        logic [31:0] wdata;
        logic        busy;
    } rsp_t;

    rsp_t sb[$];

    function automatic req_t mk(logic w, logic [1:0] s, logic g,
                                logic [23:0] a, logic [31:0] d);
        req_t r;
        r.w = w; r.s = s; r.g = g; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic rsp_t ex(logic [31:0] rd, logic f, int lat,
                                int wc, logic [31:0] wd);
        rsp_t e;
        e.rdata = rd; e.fault = f; e.lat = lat; e.wcnt = wc;
        e.rcnt = 1; e.wdata = wd; e.busy = 1'b0;
        return e;
    endfunction

    // Drives one request and observes a bounded 6-cycle window.
    task automatic run_req(input req_t r, output rsp_t o);
        o.rdata = 32'hx; o.fault = 1'bx; o.lat = 0;
        o.wcnt = 0; o.rcnt = 0; o.wdata = 32'h0; o.busy = 1'b1;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = r.w;
        bus.req_size   = r.s;
        bus.req_signed = r.g;
        bus.req_addr   = r.a;
        bus.req_wdata  = r.d;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) o.busy = bus.req_ready;
            if (bus.mem_wren) begin
                o.wcnt++;
                o.wdata = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                o.rcnt++;
                if (o.lat == 0) begin
                    o.lat   = c;
                    o.rdata = bus.resp_rdata;
                    o.fault = bus.resp_fault;
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (bus.resp_valid !== 1'b0)
            $display("FAIL reset resp_valid got %b want 0", bus.resp_valid);
        else passes++;
        total++;
        if (bus.resp_rdata !== 32'h0)
            $display("FAIL reset resp_rdata got %h want 0", bus.resp_rdata);
        else passes++;
        total++;
        if (bus.resp_fault !== 1'b0)
            $display("FAIL reset resp_fault got %b want 0", bus.resp_fault);
        else passes++;
        total++;
        if (bus.mem_addr !== 24'h0 || bus.mem_wdata !== 32'h0)
            $display("FAIL reset mem_addr/wdata got %h/%h want 0/0",
                     bus.mem_addr, bus.mem_wdata);
        else passes++;
        total++;
        if (bus.req_ready !== 1'b0 || bus.mem_wren !== 1'b0)
            $display("FAIL reset ready/wren got %b/%b want 0/0",
                     bus.req_ready, bus.mem_wren);
        else passes++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL reset_release req_ready got %b want 1",
                     bus.req_ready);
        else passes++;
    endtask

    // Runs a table of requests through the scoreboard.
    task automatic run_table(input string nm, input req_t rq[$],
                             input rsp_t ev[$]);
        rsp_t got;
        rsp_t want;
        for (int i = 0; i < rq.size(); i++) begin
            sb.push_back(ev[i]);
            run_req(rq[i], got);
            want = sb.pop_front();
            total++;
            if (got.lat !== want.lat)
                $display("FAIL %s[%0d] latency got %0d want %0d",
                         nm, i, got.lat, want.lat);
            else passes++;
            total++;
            if (got.rdata !== want.rdata || got.fault !== want.fault)
                $display("FAIL %s[%0d] rdata/fault got %h/%b want %h/%b",
                         nm, i, got.rdata, got.fault,
                         want.rdata, want.fault);
            else passes++;
            total++;
            if (got.wcnt !== want.wcnt || got.rcnt !== want.rcnt)
                $display("FAIL %s[%0d] wren/resp cycles got %0d/%0d want %0d/%0d",
                         nm, i, got.wcnt, got.rcnt, want.wcnt, want.rcnt);
            else passes++;
            if (want.wcnt != 0) begin
                total++;
                if (got.wdata !== want.wdata)
                    $display("FAIL %s[%0d] mem_wdata got %h want %h",
                             nm, i, got.wdata, want.wdata);
                else passes++;
            end
            total++;
            if (got.busy !== want.busy)
                $display("FAIL %s[%0d] req_ready in ACCESS got %b want 0",
                         nm, i, got.busy);
            else passes++;
        end
    endtask

    task automatic test_load_unsigned_word();
        req_t rq[$];
        rsp_t ev[$];
        mem[4] = 32'h11223344;
        rq.push_back(mk(0, 2'b00, 0, 24'h13, 0));
        ev.push_back(ex(32'h00000011, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b00, 1, 24'h10, 0));
        ev.push_back(ex(32'h00000044, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b10, 0, 24'h11, 0));
        ev.push_back(ex(32'h44112233, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b10, 0, 24'h10, 0));
        ev.push_back(ex(32'h11223344, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b11, 1, 24'h13, 0));
        ev.push_back(ex(32'h22334411, 0, 2, 0, 0));
        run_table("load_uw", rq, ev);
    endtask

    task automatic test_load_signed();
        req_t rq[$];
        rsp_t ev[$];
        mem[4] = 32'h80FF1234;
        rq.push_back(mk(0, 2'b01, 1, 24'h12, 0));
        ev.push_back(ex(32'hFFFF80FF, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b01, 0, 24'h12, 0));
        ev.push_back(ex(32'h000080FF, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b00, 1, 24'h13, 0));
        ev.push_back(ex(32'hFFFFFF80, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b01, 1, 24'h10, 0));
        ev.push_back(ex(32'h00001234, 0, 2, 0, 0));
        run_table("load_sg", rq, ev);
    endtask

    task automatic test_stores();
        req_t rq[$];
        rsp_t ev[$];
        mem[4] = 32'h11223344;
        mem[5] = 32'h00000000;
        rq.push_back(mk(1, 2'b00, 0, 24'h12, 32'h000000AB));
        ev.push_back(ex(32'h0, 0, 3, 1, 32'h11AB3344));
        rq.push_back(mk(1, 2'b01, 1, 24'h10, 32'h1234BEEF));
        ev.push_back(ex(32'h0, 0, 3, 1, 32'h11ABBEEF));
        rq.push_back(mk(1, 2'b10, 0, 24'h15, 32'hCAFEF00D));
        ev.push_back(ex(32'h0, 0, 2, 1, 32'hCAFEF00D));
        run_table("store", rq, ev);
        total++;
        if (mem[4] !== 32'h11ABBEEF || mem[5] !== 32'hCAFEF00D)
            $display("FAIL store_mem got %h/%h want 11abbeef/cafef00d",
                     mem[4], mem[5]);
        else passes++;
    endtask

    task automatic test_fault();
        req_t rq[$];
        rsp_t ev[$];
        mem[4] = 32'h11223344;
        rq.push_back(mk(1, 2'b01, 0, 24'h13, 32'h0000BEEF));
        ev.push_back(ex(32'h0, 1, 1, 0, 0));
        rq.push_back(mk(0, 2'b01, 1, 24'h11, 0));
        ev.push_back(ex(32'h0, 1, 1, 0, 0));
        ev[0].busy = 1'bx;
        ev[1].busy = 1'bx;
        rq.push_back(mk(0, 2'b00, 0, 24'h11, 0));
        ev.push_back(ex(32'h00000033, 0, 2, 0, 0));
        // Fault responses go straight to RESP, so req_ready at the
        // first cycle is 0 as well.
        ev[0].busy = 1'b0;
        ev[1].busy = 1'b0;
        run_table("fault", rq, ev);
        total++;
        if (mem[4] !== 32'h11223344)
            $display("FAIL fault_mem got %h want 11223344", mem[4]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        req_t rq[$];
        rsp_t ev[$];
        mem[9] = 32'hDEADBEEF;
        rq.push_back(mk(1, 2'b00, 0, 24'h24, 32'h00000055));
        ev.push_back(ex(32'h0, 0, 3, 1, 32'hDEADBE55));
        rq.push_back(mk(0, 2'b10, 0, 24'h24, 0));
        ev.push_back(ex(32'hDEADBE55, 0, 2, 0, 0));
        rq.push_back(mk(0, 2'b00, 1, 24'h24, 0));
        ev.push_back(ex(32'h00000055, 0, 2, 0, 0));
        run_table("b2b", rq, ev);
    endtask

    task automatic test_reset_mid_write();
        int wc;
        int rc;
        mem[8] = 32'hA5A5A5A5;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 24'h21;
        bus.req_wdata  = 32'h00000055;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.mem_wren !== 1'b0)
            $display("FAIL rst_mid wren_gated got %b want 0", bus.mem_wren);
        else passes++;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL rst_mid req_ready got %b want 1", bus.req_ready);
        else passes++;
        wc = 0;
        rc = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (bus.mem_wren) wc++;
            if (bus.resp_valid) rc++;
        end
        total++;
        if (wc != 0 || rc != 0)
            $display("FAIL rst_mid wren/resp got %0d/%0d want 0/0", wc, rc);
        else passes++;
        total++;
        if (mem[8] !== 32'hA5A5A5A5)
            $display("FAIL rst_mid mem got %h want a5a5a5a5", mem[8]);
        else passes++;
    endtask

    initial begin
        passes = 0;
        total  = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 24'h0;
        bus.req_wdata  = 32'h0;
        reset_n = 1'b0;
        test_reset();
        test_load_unsigned_word();
        test_load_signed();
        test_stores();
        test_fault();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
